// File: rtl/irq_dispatch_pkg.sv
// irq_dispatch shared definitions: sizes, FSM encoding, config register map.
package irq_pkg;

  localparam int unsigned NUM_IRQ = 16;
  localparam int unsigned IRQ_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } irq_state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_EDGE = 2'd1;
  localparam logic [1:0] CFG_SET  = 2'd2;
  localparam logic [1:0] CFG_CLR  = 2'd3;

endpackage

// File: rtl/irq_dispatch_if.sv
// Issue/acknowledge link between the interrupt dispatcher (master) and the
// tile frontend (slave).
interface irq_dispatch_if;
  import irq_pkg::*;

  logic             irqload;
  logic [IRQ_W-1:0] irqnum;
  logic             irq_hold;
  logic             irq_ack;
  logic [IRQ_W-1:0] irq_ack_num;

  modport master (
    output irqload, irqnum,
    input  irq_hold, irq_ack, irq_ack_num
  );

  modport slave (
    input  irqload, irqnum,
    output irq_hold, irq_ack, irq_ack_num
  );

endinterface

// File: rtl/irq_dispatch_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, bit 0 is highest priority.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [IRQ_W-1:0]   idx_o
);

  // Scan upward and keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = IRQ_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: synchronises 16 lines, applies mask and edge/level
// mode, issues the highest-priority pending vector as a one-cycle irqload
// pulse and holds off until the matching ack plus a gap.
// Optional build macro IRQ_TIMEOUT_EN: re-arbitrate after TIMEOUT WAIT cycles.
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned RST_QUIET   = 5
`ifdef IRQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT   = 1023
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  irq_dispatch_if.master     fe,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_busy
);

  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned QUIET_W = (RST_QUIET > 1) ? $clog2(RST_QUIET + 1) : 1;
`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] s, s_dly_q, rise;
  logic [NUM_IRQ-1:0] mask_q, edge_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, set_v, clr_v;
  logic [NUM_IRQ-1:0] enabled;
  logic               enc_valid;
  logic [IRQ_W-1:0]   enc_idx;
  irq_state_e         state_q, state_d;
  logic [IRQ_W-1:0]   irqnum_q, irqnum_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [QUIET_W-1:0] quiet_q;
  logic               ack_hit;
`ifdef IRQ_TIMEOUT_EN
  logic [TO_W-1:0]    to_q, to_d;
`endif

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_dly_q;
  assign enabled = pend_q & mask_q;
  assign ack_hit = (state_q == WAIT) && fe.irq_ack && (fe.irq_ack_num == irqnum_q);

  irq_prio_enc u_prio (
    .req_i   (enabled),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // Synchroniser chain plus one-cycle delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      s_dly_q <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_dly_q <= s;
    end
  end

  // Mask and edge-mode configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      edge_q <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == CFG_MASK) mask_q <= cfg_wdata;
      if (cfg_addr == CFG_EDGE) edge_q <= cfg_wdata;
    end
  end

  // Pending next-state: all set sources beat all clear sources.
  // The ack clear is keyed on the latched irqnum, not the mask, so a source
  // masked after issue is still retired by its ack.
  always_comb begin
    set_v = (edge_q & rise) | (~edge_q & s);
    clr_v = ~edge_q & ~s;
    if (cfg_we && cfg_addr == CFG_SET) set_v = set_v | cfg_wdata;
    if (cfg_we && cfg_addr == CFG_CLR) clr_v = clr_v | cfg_wdata;
    if (ack_hit) clr_v[irqnum_q] = clr_v[irqnum_q] | edge_q[irqnum_q];
    pend_d = set_v | (pend_q & ~clr_v);
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Post-reset quiet window counter.
  always_ff @(posedge clk) begin
    if (rst)                quiet_q <= QUIET_W'(RST_QUIET);
    else if (quiet_q != '0) quiet_q <= quiet_q - QUIET_W'(1);
  end

  // FSM next-state, vector latch and hold-off counters.
  always_comb begin
    state_d  = state_q;
    irqnum_d = irqnum_q;
    gap_d    = gap_q;
`ifdef IRQ_TIMEOUT_EN
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (enc_valid && !fe.irq_hold && quiet_q == '0) begin
          irqnum_d = enc_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef IRQ_TIMEOUT_EN
        to_d    = '0;
`endif
      end
      WAIT: begin
        if (ack_hit) begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
        end
`ifdef IRQ_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      irqnum_q <= '0;
      gap_q    <= '0;
`ifdef IRQ_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      irqnum_q <= irqnum_d;
      gap_q    <= gap_d;
`ifdef IRQ_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign fe.irqload  = (state_q == ISSUE);
  assign fe.irqnum   = irqnum_q;
  assign irq_pending = pend_q;
  assign irq_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed self-checking bench for irq_dispatch.
module tb_irq_dispatch;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] irq_pending;
  logic        irq_busy;

  always #5 clk = ~clk;

  irq_dispatch_if fe_if ();

  irq_dispatch #(
    .SYNC_STAGES (2),
    .GAP_CYCLES  (4),
    .RST_QUIET   (5)
`ifdef IRQ_TIMEOUT_EN
    , .TIMEOUT   (8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .fe          (fe_if.master),
    .irq_pending (irq_pending),
    .irq_busy    (irq_busy)
  );

  typedef struct {
    logic        rst;
    logic [15:0] src;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wd;
    logic        hold;
    logic        ack;
    logic [3:0]  anum;
    logic        e_load;
    logic [3:0]  e_num;
    logic [15:0] e_pend;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [15:0] src, input logic we, input logic [1:0] addr,
                     input logic [15:0] wd, input logic hold, input logic ack, input logic [3:0] anum,
                     input logic el, input logic [3:0] en, input logic [15:0] ep, input logic eb);
    vec_t v;
    v.rst = r; v.src = src; v.we = we; v.addr = addr; v.wd = wd; v.hold = hold;
    v.ack = ack; v.anum = anum; v.e_load = el; v.e_num = en; v.e_pend = ep; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  // Plain idle cycle with only expectations given.
  task automatic idl(input logic el, input logic [3:0] en, input logic [15:0] ep, input logic eb);
    add(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd0, el, en, ep, eb);
  endtask

  task automatic ackv(input logic [3:0] n, input logic [3:0] en, input logic [15:0] ep);
    add(1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1, n, 1'b0, en, ep, 1'b1);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
  endtask

  task automatic ack(input logic [3:0] n);
    fe_if.irq_ack = 1'b1; fe_if.irq_ack_num = n;
    cyc();
    fe_if.irq_ack = 1'b0; fe_if.irq_ack_num = 4'd0;
  endtask

  task automatic wait_pulse(input int max, output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < max) begin
      cyc();
      n++;
      if (fe_if.irqload === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int n;

    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    fe_if.irq_hold = 1'b0; fe_if.irq_ack = 1'b0; fe_if.irq_ack_num = '0;

    // Reset and quiet window: pending set early, issue only once quiet reaches 0.
    repeat (3) add(1'b1, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
    add(1'b0, 16'h0, 1'b1, CFG_EDGE, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
    add(1'b0, 16'h0, 1'b1, CFG_MASK, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
    add(1'b0, 16'h0, 1'b1, CFG_SET,  16'h0001, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0001, 1'b0);
    idl(0, 0, 16'h0001, 0);
    idl(0, 0, 16'h0001, 0);
    idl(1, 0, 16'h0001, 1);
    idl(0, 0, 16'h0001, 1);
    ackv(4'd0, 4'd0, 16'h0000);
    repeat (3) idl(0, 0, 16'h0000, 1);
    idl(0, 0, 16'h0000, 0);
    // Priority: bits 9 and 3 pulse together, 3 first, 9 after ack and gap.
    add(1'b0, 16'h0208, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idl(0, 0, 16'h0000, 0);
    idl(0, 0, 16'h0208, 0);
    idl(1, 3, 16'h0208, 1);
    idl(0, 3, 16'h0208, 1);
    ackv(4'd3, 4'd3, 16'h0200);
    repeat (3) idl(0, 3, 16'h0200, 1);
    idl(0, 3, 16'h0200, 0);
    idl(1, 9, 16'h0200, 1);
    idl(0, 9, 16'h0200, 1);
    ackv(4'd9, 4'd9, 16'h0000);
    repeat (3) idl(0, 9, 16'h0000, 1);
    idl(0, 9, 16'h0000, 0);
    // Wrong ack number is ignored; correct one clears pending.
    add(1'b0, 16'h0, 1'b1, CFG_SET, 16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 16'h0020, 1'b0);
    idl(1, 5, 16'h0020, 1);
    idl(0, 5, 16'h0020, 1);
    ackv(4'd6, 4'd5, 16'h0020);
    ackv(4'd5, 4'd5, 16'h0000);
    repeat (3) idl(0, 5, 16'h0000, 1);
    idl(0, 5, 16'h0000, 0);
    // Hold blocks issue; set (edge 4) beats clear (addr 3) in the same cycle.
    add(1'b0, 16'h0000, 1'b1, CFG_SET, 16'h0001, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 16'h0001, 1'b0);
    add(1'b0, 16'h0010, 1'b0, 2'd0,    16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 16'h0001, 1'b0);
    add(1'b0, 16'h0010, 1'b0, 2'd0,    16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 16'h0001, 1'b0);
    add(1'b0, 16'h0010, 1'b1, CFG_CLR, 16'h0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 16'h0011, 1'b0);
    idl(1, 0, 16'h0011, 1);
    idl(0, 0, 16'h0011, 1);
    ackv(4'd0, 4'd0, 16'h0010);
    repeat (3) idl(0, 0, 16'h0010, 1);
    idl(0, 0, 16'h0010, 0);
    idl(1, 4, 16'h0010, 1);
    idl(0, 4, 16'h0010, 1);
    ackv(4'd4, 4'd4, 16'h0000);
    repeat (3) idl(0, 4, 16'h0000, 1);
    idl(0, 4, 16'h0000, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; irq_src = tbl[i].src;
      cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wd;
      fe_if.irq_hold = tbl[i].hold; fe_if.irq_ack = tbl[i].ack; fe_if.irq_ack_num = tbl[i].anum;
      cyc();
      tests++;
      if (fe_if.irqload !== tbl[i].e_load || fe_if.irqnum !== tbl[i].e_num ||
          irq_pending !== tbl[i].e_pend || irq_busy !== tbl[i].e_busy) begin
        fails++;
        $display("FAIL vec%0d: got load=%b num=%0d pend=%h busy=%b expected load=%b num=%0d pend=%h busy=%b",
                 i, fe_if.irqload, fe_if.irqnum, irq_pending, irq_busy,
                 tbl[i].e_load, tbl[i].e_num, tbl[i].e_pend, tbl[i].e_busy);
      end
    end

    rst = 1'b0; irq_src = '0; cfg_we = 1'b0; fe_if.irq_hold = 1'b0;
    fe_if.irq_ack = 1'b0; fe_if.irq_ack_num = '0;

    // Level source 2 held high is re-issued after the gap; dropping it ends issue.
    cfg(CFG_EDGE, 16'hFFFB);
    irq_src = 16'h0004;
    wait_pulse(20, found, n);
    chk("lvl_first_pulse", found, 1);
    chk("lvl_first_num", fe_if.irqnum, 2);
    cyc();
    ack(4'd2);
    chk("lvl_pend_held", irq_pending[2], 1);
    wait_pulse(20, found, n);
    chk("lvl_reissue", found, 1);
    chk("lvl_reissue_num", fe_if.irqnum, 2);
    irq_src = 16'h0000;
    repeat (4) cyc();
    chk("lvl_pend_drop", irq_pending[2], 0);
    chk("lvl_busy_wait", irq_busy, 1);
    ack(4'd2);
    wait_pulse(20, found, n);
    chk("lvl_no_more_pulse", found, 0);
    chk("lvl_idle", irq_busy, 0);

    // Reset while waiting for ack: back to IDLE, everything cleared, no pulse.
    cfg(CFG_SET, 16'h8000);
    wait_pulse(20, found, n);
    chk("rst_pre_pulse", found, 1);
    chk("rst_pre_num", fe_if.irqnum, 15);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_state", {fe_if.irqload, irq_busy, fe_if.irqnum, irq_pending}, 22'h0);
    rst = 1'b0;
    wait_pulse(10, found, n);
    chk("rst_mid_no_pulse", found, 0);

`ifdef IRQ_TIMEOUT_EN
    // Unacked vector 7 times out; newly pending source 1 wins re-arbitration.
    cfg(CFG_MASK, 16'hFFFF);
    cfg(CFG_EDGE, 16'hFFFF);
    cfg(CFG_SET, 16'h0080);
    wait_pulse(20, found, n);
    chk("to_first_pulse", found, 1);
    chk("to_first_num", fe_if.irqnum, 7);
    irq_src = 16'h0002;
    wait_pulse(30, found, n);
    chk("to_reissue", found, 1);
    chk("to_reissue_delay", n, 10);
    chk("to_reissue_num", fe_if.irqnum, 1);
    chk("to_pend7_kept", irq_pending[7], 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
